// File: rtl/ula_contention.sv
// ULA-style memory/IO contention: free-running 224x312 raster counters, frame
// interrupt, and a registered nWAIT that stretches CPU accesses to 0x4000-0x7FFF.
module ula_contention #(
  parameter int H_LAST   = 223,
  parameter int V_LAST   = 311,
  parameter int WIN_V_LO = 64,
  parameter int WIN_V_HI = 255,
  parameter int WIN_H_HI = 127,
  parameter int INT_LEN  = 32
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nM1,
  input  logic        nRFSH,
  input  logic        en,
  output logic        nWAIT,
  output logic        nINT,
  output logic [7:0]  hcnt,
  output logic [8:0]  vcnt
);

  localparam logic [7:0] HLAST = 8'(H_LAST);
  localparam logic [8:0] VLAST = 9'(V_LAST);
  localparam logic [8:0] VLO   = 9'(WIN_V_LO);
  localparam logic [8:0] VHI   = 9'(WIN_V_HI);
  localparam logic [7:0] HHI   = 8'(WIN_H_HI);
  localparam logic [7:0] ILEN  = 8'(INT_LEN);

  logic [7:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       nwait_q, nwait_d;
  logic       nint_q, nint_d;
  logic       nmreq_q, niorq_q;

  logic       window, mem_start, io_start, start;
  logic [2:0] delay;
  logic       unused_a;

  assign unused_a = ^A[13:1];

  // Raster counters never stall: they are the timing reference for the display.
  always_comb begin
    hcnt_d = hcnt_q + 8'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLAST) begin
      hcnt_d = 8'd0;
      vcnt_d = (vcnt_q == VLAST) ? 9'd0 : vcnt_q + 9'd1;
    end
    nint_d = !(vcnt_q == 9'd0 && hcnt_q < ILEN);
  end

  assign window = (vcnt_q >= VLO) && (vcnt_q <= VHI) && (hcnt_q <= HHI);

  // Remaining cycles until the ULA's 8-T fetch slot frees up the bus.
  always_comb begin
    case (hcnt_q[2:0])
      3'd0:    delay = 3'd6;
      3'd1:    delay = 3'd5;
      3'd2:    delay = 3'd4;
      3'd3:    delay = 3'd3;
      3'd4:    delay = 3'd2;
      3'd5:    delay = 3'd1;
      default: delay = 3'd0;
    endcase
  end

  // Only the first cycle of an access counts; refresh and int-ack never contend.
  assign mem_start = !nMREQ && nmreq_q && nRFSH && (A[15:14] == 2'b01);
  assign io_start  = !nIORQ && niorq_q && nM1 && !A[0];
  assign start     = mem_start || io_start;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!en)
      wait_cnt_d = 3'd0;
    else if (start && window && wait_cnt_q == 3'd0)
      wait_cnt_d = delay;
    else if (wait_cnt_q != 3'd0)
      wait_cnt_d = wait_cnt_q - 3'd1;
    nwait_d = (wait_cnt_d == 3'd0);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      hcnt_q     <= 8'd0;
      vcnt_q     <= 9'd0;
      wait_cnt_q <= 3'd0;
      nwait_q    <= 1'b1;
      nint_q     <= 1'b1;
      nmreq_q    <= 1'b1;
      niorq_q    <= 1'b1;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      wait_cnt_q <= wait_cnt_d;
      nwait_q    <= nwait_d;
      nint_q     <= nint_d;
      nmreq_q    <= nMREQ;
      niorq_q    <= nIORQ;
    end
  end

  assign nWAIT = nwait_q;
  assign nINT  = nint_q;
  assign hcnt  = hcnt_q;
  assign vcnt  = vcnt_q;

endmodule

// File: tb/tb_ula_contention.sv
// Bench for ula_contention: vector table, hand sequences and random accesses,
// all checked every cycle against an event-level model of waits and raster.
`timescale 1ns/1ps
module tb_ula_contention;
  localparam int FRAME = 69888;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] A = 16'h0000;
  logic        nMREQ = 1'b1, nIORQ = 1'b1, nM1 = 1'b1, nRFSH = 1'b1, en = 1'b1;
  wire         nWAIT, nINT;
  wire  [7:0]  hcnt;
  wire  [8:0]  vcnt;

  ula_contention dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nM1(nM1), .nRFSH(nRFSH), .en(en), .nWAIT(nWAIT), .nINT(nINT),
    .hcnt(hcnt), .vcnt(vcnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int edges = 0, wstart = 0, wend = 0;
  logic pm = 1'b1, pi = 1'b1;
  int lows = 0, intlo1 = 0, intlo2 = 0;

  typedef struct {
    int          v;
    int          h;
    logic [15:0] a;
    int          kind;  // 0 mem, 1 refresh, 2 io, 3 int-ack
    int          exp;   // expected nWAIT low cycles
    string       name;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edges);
    end
  endtask

  // Model: a wait is an interval of edges [wstart, wend) during which nWAIT is low.
  task automatic step();
    int pos, h, v, k, d;
    bit win, ms, is, ei;
    pos = edges % FRAME;
    h = pos % 224;
    v = pos / 224;
    k = edges + 1;
    win = (v >= 64 && v <= 255 && h <= 127);
    d = (h % 8 == 7) ? 0 : 6 - (h % 8);
    ms = !nMREQ && pm && nRFSH && (A[15:14] == 2'b01);
    is = !nIORQ && pi && nM1 && !A[0];
    if (!en) begin
      if (wend > k) wend = k;
    end else if ((ms || is) && win && k > wend) begin
      wstart = k;
      wend = k + d;
    end
    ei = !(v == 0 && h < 32);
    pm = nMREQ;
    pi = nIORQ;
    @(posedge CLK);
    edges = k;
    #1;
    chk("hcnt", 32'(hcnt), 32'((k % FRAME) % 224));
    chk("vcnt", 32'(vcnt), 32'((k % FRAME) / 224));
    chk("nINT", 32'(nINT), 32'(ei));
    chk("nWAIT", 32'(nWAIT), 32'(!(k >= wstart && k < wend)));
    if (!nWAIT) lows++;
    if (!nINT) begin
      if (k <= FRAME) intlo1++;
      else intlo2++;
    end
  endtask

  task automatic run_to(input int t);
    while (edges < t) step();
  endtask

  task automatic idle_bus();
    nMREQ = 1'b1; nIORQ = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
  endtask

  task automatic access(input int kind, input logic [15:0] a, input int hold);
    A = a;
    case (kind)
      0: nMREQ = 1'b0;
      1: begin nMREQ = 1'b0; nRFSH = 1'b0; end
      2: nIORQ = 1'b0;
      default: begin nIORQ = 1'b0; nM1 = 1'b0; end
    endcase
    repeat (hold) step();
    idle_bus();
  endtask

  task automatic run_vec(input int i);
    run_to(tbl[i].v * 224 + tbl[i].h);
    lows = 0;
    access(tbl[i].kind, tbl[i].a, 3);
    repeat (9) step();
    chk(tbl[i].name, 32'(lows), 32'(tbl[i].exp));
  endtask

  task automatic model_reset();
    edges = 0; wstart = 0; wend = 0;
    pm = 1'b1; pi = 1'b1;
    lows = 0; intlo1 = 0; intlo2 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, edges %0d", edges);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{63,  0,   16'h4000, 0, 0, "v63_no_wait"};
    tbl[1]  = '{64,  0,   16'h4000, 0, 6, "v64_h0_6"};
    tbl[2]  = '{65,  3,   16'h4000, 0, 3, "h3_3"};
    tbl[3]  = '{66,  6,   16'h4000, 0, 0, "h6_none"};
    tbl[4]  = '{67,  7,   16'h4000, 0, 0, "h7_none"};
    tbl[5]  = '{68,  128, 16'h4000, 0, 0, "h128_none"};
    tbl[6]  = '{69,  8,   16'h8000, 0, 0, "a8000_none"};
    tbl[7]  = '{70,  8,   16'h0000, 0, 0, "a0000_none"};
    tbl[8]  = '{71,  8,   16'h4000, 1, 0, "refresh_none"};
    tbl[9]  = '{72,  124, 16'h7FFF, 0, 2, "h124_2"};
    tbl[10] = '{73,  125, 16'h4000, 0, 1, "h125_1"};
    tbl[11] = '{100, 1,   16'h00FE, 2, 5, "io_fe_5"};
    tbl[12] = '{101, 1,   16'h001F, 2, 0, "io_1f_none"};
    tbl[13] = '{102, 1,   16'h00FE, 3, 0, "intack_none"};
    tbl[14] = '{103, 2,   16'h80FE, 2, 4, "io_80fe_4"};
    tbl[15] = '{104, 0,   16'hC0FE, 2, 6, "io_c0fe_6"};
    tbl[16] = '{255, 120, 16'h4000, 0, 6, "v255_6"};
    tbl[17] = '{256, 0,   16'h4000, 0, 0, "v256_none"};

    // Reset values, held across clock edges.
    #23;
    chk("rst_hcnt", 32'(hcnt), 0);
    chk("rst_vcnt", 32'(vcnt), 0);
    chk("rst_nWAIT", 32'(nWAIT), 1);
    chk("rst_nINT", 32'(nINT), 1);
    @(posedge CLK); #1;
    nRESET = 1'b1;
    model_reset();

    for (int i = 0; i <= 10; i++) run_vec(i);

    // Async reset in the middle of a 6-cycle wait at line 80.
    run_to(80 * 224);
    A = 16'h4000; nMREQ = 1'b0;
    step(); step();
    chk("pre_reset_nWAIT", 32'(nWAIT), 0);
    #2 nRESET = 1'b0;
    #1;
    chk("async_nWAIT", 32'(nWAIT), 1);
    chk("async_hcnt", 32'(hcnt), 0);
    chk("async_vcnt", 32'(vcnt), 0);
    chk("async_nINT", 32'(nINT), 1);
    idle_bus();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hold_hcnt", 32'(hcnt), 0);
    nRESET = 1'b1;
    model_reset();
    step();
    chk("first_edge_nINT", 32'(nINT), 0);

    for (int i = 11; i <= 15; i++) run_vec(i);

    // A second access edge during a wait must not extend it.
    run_to(110 * 224);
    lows = 0;
    A = 16'h4000; nMREQ = 1'b0; step();
    nMREQ = 1'b1; step();
    nMREQ = 1'b0; step(); step();
    nMREQ = 1'b1;
    repeat (8) step();
    chk("stack_lows", 32'(lows), 6);

    // Dropping en mid-wait ends it at the next edge.
    run_to(111 * 224);
    lows = 0;
    nMREQ = 1'b0; step(); step();
    en = 1'b0; step();
    chk("en_off_nWAIT", 32'(nWAIT), 1);
    nMREQ = 1'b1; step();
    en = 1'b1;
    repeat (6) step();
    chk("en_off_lows", 32'(lows), 2);

    // Random traffic across window lines and horizontal positions.
    run_to(120 * 224);
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [15:0] a;
      run_to(edges + int'($urandom_range(1, 30)));
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[15:14] = 2'b01;
      en = ($urandom_range(0, 9) != 0);
      access(kind, a, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b0; step();
      end
      en = 1'b1;
      repeat ($urandom_range(0, 3)) step();
    end

    for (int i = 16; i <= 17; i++) run_vec(i);

    run_to(FRAME + 40);
    chk("nINT_lows_frame", 32'(intlo1), 32);
    chk("nINT_lows_wrap", 32'(intlo2), 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ula_contention.md
ULA_CONTENTION -- requirements
Module: ula_contention

Interface
REQ-001 SHALL have port CLK, input, 1 bit: CPU clock (3.5 MHz, 7.0 MHz in turbo); the only clock; all state updates on its rising edge.
REQ-002 SHALL have port nRESET, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port A, input, 16 bits: CPU address bus.
REQ-004 SHALL have port nMREQ, input, 1 bit: CPU memory request, active-low.
REQ-005 SHALL have port nIORQ, input, 1 bit: CPU I/O request, active-low.
REQ-006 SHALL have port nM1, input, 1 bit: CPU M1, active-low; identifies interrupt acknowledge (nIORQ and nM1 both low).
REQ-007 SHALL have port nRFSH, input, 1 bit: CPU refresh, active-low.
REQ-008 SHALL have port en, input, 1 bit: contention enable; 0 disables wait insertion (turbo or debug).
REQ-009 SHALL have port nWAIT, output, 1 bit: registered wait request to the CPU, active-low.
REQ-010 SHALL have port nINT, output, 1 bit: registered frame interrupt, active-low.
REQ-011 SHALL have port hcnt, output, 8 bits: T-state within the line, 0..223.
REQ-012 SHALL have port vcnt, output, 9 bits: line within the frame, 0..311.

Function
REQ-013 hcnt SHALL increment every cycle; at 223 it wraps to 0 and vcnt increments; vcnt wraps from 311 to 0, giving a frame of 69888 cycles.
REQ-014 Counters SHALL run continuously, independent of en, nWAIT and bus activity.
REQ-015 nINT SHALL be registered: nINT <= NOT(vcnt==0 AND hcnt<32), using pre-edge counter values; this produces exactly 32 low cycles per frame.
REQ-016 Window SHALL be defined as vcnt in 64..255 inclusive AND hcnt in 0..127 inclusive.
REQ-017 Delay SHALL be given by hcnt[2:0] = 0,1,2,3,4,5,6,7 -> 6,5,4,3,2,1,0,0 cycles.
REQ-018 Previous-cycle copies nMREQ_q and nIORQ_q SHALL be registered; each resets to 1.
REQ-019 A memory start SHALL occur when: nMREQ==0, nMREQ_q==1, nRFSH==1, and A[15:14]==2'b01.
REQ-020 An I/O start SHALL occur when: nIORQ==0, nIORQ_q==1, nM1==1, and A[0]==0, regardless of A[15:14].
REQ-021 When en==1, a start occurs, the window is true, and wait_cnt==0, then wait_cnt (3 bits) SHALL load the delay for the current hcnt.
REQ-022 Otherwise, when wait_cnt!=0, wait_cnt SHALL decrement by 1 per cycle.
REQ-023 nWAIT SHALL equal (wait_cnt==0) as held in a register, so nWAIT is low from the cycle after the start edge for exactly delay cycles; a delay of 0 produces no assertion.
REQ-024 A start while wait_cnt!=0 SHALL be ignored; waits SHALL neither stack nor restart.
REQ-025 A start outside the window, or with delay 0, SHALL leave nWAIT high.
REQ-026 en==0 SHALL force wait_cnt to 0 on the next edge, ending any wait in progress; counters and nINT are unaffected.
REQ-027 Refresh cycles and interrupt-acknowledge cycles SHALL never be contended.

Reset
REQ-028 While nRESET==0, the block SHALL hold: hcnt=0, vcnt=0, wait_cnt=0, nWAIT=1, nINT=1, nMREQ_q=1, nIORQ_q=1.
REQ-029 nRESET assertion SHALL take effect immediately, including mid-wait (nWAIT goes high without a clock); the first edge after release SHALL count normally from 0/0.

Verification
REQ-030 Release reset, run 69888+40 cycles -> nINT low after edges 1..32, high otherwise, low again after edges 69889..69920; hcnt/vcnt wrap at 223/311.
REQ-031 en=1; nMREQ falls with A=0x4000 at vcnt=64, hcnt=0 -> nWAIT low exactly 6 cycles; the same at hcnt=3 -> 3 cycles; at hcnt=6 or 7 -> none.
REQ-032 A=0x4000 access at vcnt=63, vcnt=256, or hcnt=128 -> no wait; access to A=0x8000 or 0x0000 inside the window -> no wait; refresh with A=0x4000 -> no wait.
REQ-033 I/O read of port 0x00FE at vcnt=100, hcnt=1 -> 5-cycle wait; port 0x001F -> none; interrupt acknowledge (nM1=0, nIORQ=0) -> none.
REQ-034 Second nMREQ falling edge during an active 6-cycle wait -> ignored, total low stays 6; en=0 mid-wait -> nWAIT high after next edge.
REQ-035 nRESET pulsed low mid-wait at vcnt=80 -> nWAIT=1 and counters=0 immediately, no clock needed; nINT goes low on the first edge after release.
